turn_sequencer: RTL

Two-player turn controller for the snakes-and-ladders game. It accepts a player's roll request, pulses the dice, and captures the die value. It then computes the capped move, applies the external snake/ladder lookup, and checks for a win. It owns both position registers and decides whose turn is next: a rolled 6 grants a bonus turn, and a run of consecutive 6s ends in a forfeit. It sits between the user roll input, the dice block and the combinational snake/ladder map, and replaces the free-running player_switch scheme.

---
 rtl/turn_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/turn_sequencer.sv
// Two-player snakes-and-ladders turn controller: roll handshake with the dice
// block, capped move, external snake/ladder lookup, bonus turns on a 6 and win detection.
module turn_sequencer #(
  parameter int WIN_POS   = 100,
  parameter int MAX_SIXES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_req,
  input  logic [2:0] dice_value,
  input  logic [6:0] jump_pos,
  output logic       roll_en,
  output logic [6:0] move_pos,
  output logic [6:0] position1,
  output logic [6:0] position2,
  output logic       current_player,
  output logic       busy,
  output logic       turn_done,
  output logic       win1,
  output logic       win2,
  output logic       game_over
);

  localparam int              SW       = $clog2(MAX_SIXES) + 1;
  localparam logic [SW-1:0]   SIX_LAST = SW'(MAX_SIXES - 1);
  localparam logic [6:0]      WIN7     = 7'(WIN_POS);
  localparam logic [7:0]      WIN8     = 8'(WIN_POS);

  typedef enum logic [2:0] {IDLE, ROLL, CAPTURE, MOVE, RESOLVE, CHECK, DONE} state_e;

  state_e          state_q;
  logic [1:0][6:0] pos_q;
  logic [SW-1:0]   six_cnt_q;
  logic [2:0]      die_q;
  logic [6:0]      pos_tent_q;
  logic            cur_q;
  logic            roll_en_q;
  logic            busy_q;
  logic            turn_done_q;
  logic [1:0]      win_q;

  logic [6:0] cur_pos;
  logic [7:0] sum;
  logic       forfeit;

  assign cur_pos = pos_q[cur_q];
  assign sum     = {1'b0, cur_pos} + {5'd0, die_q};
  // six_cnt and die_q are stable from MOVE through CHECK, so forfeit is valid in both
  assign forfeit = (die_q == 3'd6) && (six_cnt_q == SIX_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      six_cnt_q   <= '0;
      die_q       <= '0;
      pos_tent_q  <= '0;
      cur_q       <= 1'b0;
      roll_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      turn_done_q <= 1'b0;
      win_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (roll_req) begin
            state_q   <= ROLL;
            roll_en_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ROLL: begin
          roll_en_q <= 1'b0;
          state_q   <= CAPTURE;
        end
        CAPTURE: begin
          if (dice_value != 3'd0 && dice_value != 3'd7) begin
            die_q   <= dice_value;
            state_q <= MOVE;
          end else begin
            roll_en_q <= 1'b1;
            state_q   <= ROLL;
          end
        end
        MOVE: begin
          // an overshoot of the target square means the player stays put
          pos_tent_q <= (forfeit || sum > WIN8) ? cur_pos : sum[6:0];
          state_q    <= RESOLVE;
        end
        RESOLVE: begin
          pos_q[cur_q] <= jump_pos;
          turn_done_q  <= 1'b1;
          state_q      <= CHECK;
        end
        CHECK: begin
          turn_done_q <= 1'b0;
          busy_q      <= 1'b0;
          if (cur_pos == WIN7) begin
            win_q[cur_q] <= 1'b1;
            state_q      <= DONE;
          end else if (forfeit) begin
            cur_q     <= ~cur_q;
            six_cnt_q <= '0;
            state_q   <= IDLE;
          end else if (die_q == 3'd6) begin
            six_cnt_q <= six_cnt_q + SW'(1);
            state_q   <= IDLE;
          end else begin
            cur_q     <= ~cur_q;
            six_cnt_q <= '0;
            state_q   <= IDLE;
          end
        end
        DONE:    state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign roll_en        = roll_en_q;
  assign move_pos       = pos_tent_q;
  assign position1      = pos_q[0];
  assign position2      = pos_q[1];
  assign current_player = cur_q;
  assign busy           = busy_q;
  assign turn_done      = turn_done_q;
  assign win1           = win_q[0];
  assign win2           = win_q[1];
  assign game_over      = win_q[0] | win_q[1];

endmodule
